// File: rtl/memoria_dados_param.sv
// memoria_dados_param: RISC-V byte/half/word data memory with clear sweep, n_in injection, tap output and optional MEMDADOS_MISALIGN_TRAP_EN trap
module memoria_dados_param #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int N_IN_WORD  = 0,
  parameter int TAP_WORD   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  store_size,
  input  logic [1:0]  load_size,
  input  logic        load_unsigned,
  input  logic [31:0] endereco,
  input  logic [31:0] write_data,
  input  logic [31:0] n_in,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        busy,
  output logic        misalign,
  output logic [31:0] tap_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] NI_IDX  = N_IN_WORD[AW-1:0];
  localparam logic [AW-1:0] TAP_IDX = TAP_WORD[AW-1:0];
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_clr_idx;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata, r_tap;
  logic r_rvalid, r_mis;
  logic [ADDR_WIDTH-3:0] w_idx;
  logic [AW-1:0] w_widx;
  logic w_in_range, w_run, w_st, w_ld, w_ld_ok, w_ni_en, w_mis_st, w_mis_ld, w_unused;
  logic [3:0] w_be;
  logic [31:0] w_wdata, w_base, w_merged, w_rword, w_ext;
  logic [15:0] w_half;
  logic [7:0] w_byte;
  assign w_unused   = ^endereco[31:ADDR_WIDTH];
  assign w_idx      = endereco[ADDR_WIDTH-1:2];
  assign w_widx     = w_idx[AW-1:0];
  assign w_in_range = 32'(w_idx) < DEPTH;
  assign w_run      = (r_state == RUN) && !rst;
`ifdef MEMDADOS_MISALIGN_TRAP_EN
  assign w_mis_st = mem_write && (store_size[1] ? endereco[1:0] != 2'b00 : store_size[0] & endereco[0]);
  assign w_mis_ld = mem_read && (load_size[1] ? endereco[1:0] != 2'b00 : load_size[0] & endereco[0]);
`else
  assign w_mis_st = 1'b0;
  assign w_mis_ld = 1'b0;
`endif
  assign w_st    = w_run && mem_write && w_in_range && !w_mis_st;
  assign w_ld    = w_run && mem_read;
  assign w_ld_ok = w_ld && w_in_range && !w_mis_ld;
  assign w_ni_en = w_run && (N_IN_WORD < DEPTH);
  assign w_be    = store_size[1] ? 4'hF : store_size[0] ? (endereco[1] ? 4'hC : 4'h3) : 4'b0001 << endereco[1:0];
  assign w_wdata = store_size[1] ? write_data : store_size[0] ? {2{write_data[15:0]}} : {4{write_data[7:0]}};
  assign w_base  = (w_ni_en && w_widx == NI_IDX) ? n_in : r_mem[w_widx];
  assign w_merged = {w_be[3] ? w_wdata[31:24] : w_base[31:24], w_be[2] ? w_wdata[23:16] : w_base[23:16],
                     w_be[1] ? w_wdata[15:8] : w_base[15:8], w_be[0] ? w_wdata[7:0] : w_base[7:0]};
  assign w_rword = w_in_range ? r_mem[w_widx] : '0;
  assign w_byte  = w_rword[{endereco[1:0], 3'b000} +: 8];
  assign w_half  = endereco[1] ? w_rword[31:16] : w_rword[15:0];
  assign w_ext   = load_size[1] ? w_rword : load_size[0] ? {{16{w_half[15] & ~load_unsigned}}, w_half}
                                                          : {{24{w_byte[7] & ~load_unsigned}}, w_byte};
  assign read_data  = r_rdata;
  assign read_valid = r_rvalid;
  assign misalign   = r_mis;
  assign tap_data   = r_tap;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_next;
      r_clr_idx <= (r_state == CLEAR) ? r_clr_idx + 1'b1 : '0;
    end
  end
  always_comb begin
    w_next = (r_state == CLEAR && r_clr_idx == LAST) ? RUN : r_state;
    busy   = (r_state == CLEAR);
  end
  always_ff @(posedge clk) begin
    if (r_state == CLEAR && !rst) r_mem[r_clr_idx] <= '0;
    if (w_ni_en && !(w_st && w_widx == NI_IDX)) r_mem[NI_IDX] <= n_in;
    if (w_st) r_mem[w_widx] <= w_merged;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_mis    <= 1'b0;
      r_tap    <= '0;
    end else begin
      r_rdata  <= w_ld_ok ? w_ext : '0;
      r_rvalid <= w_ld;
      r_mis    <= w_run && (w_mis_st || w_mis_ld);
      r_tap    <= (r_state == RUN && TAP_WORD < DEPTH) ? r_mem[TAP_IDX] : '0;
    end
  end
endmodule

// File: tb/tb_memoria_dados_param.sv
// tb_memoria_dados_param: scoreboard bench for memoria_dados_param
module tb_memoria_dados_param;
  logic clk = 1'b0;
  logic rst, mem_write, mem_read, load_unsigned, read_valid, busy, misalign, exp_mis;
  logic [1:0] store_size, load_size;
  logic [31:0] endereco, write_data, n_in, read_data, tap_data;
  logic [31:0] sb_q [$];
  int checks = 0;
  int errors = 0;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;
  memoria_dados_param dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_read(mem_read),
    .store_size(store_size), .load_size(load_size), .load_unsigned(load_unsigned),
    .endereco(endereco), .write_data(write_data), .n_in(n_in),
    .read_data(read_data), .read_valid(read_valid), .busy(busy),
    .misalign(misalign), .tap_data(tap_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step(input logic w, input logic r, input logic [1:0] ss, input logic [1:0] ls,
                      input logic u, input logic [31:0] a, input logic [31:0] wd,
                      input logic push, input logic [31:0] exp);
    mem_write = w;
    mem_read = r;
    store_size = ss;
    load_size = ls;
    load_unsigned = u;
    endereco = a;
    write_data = wd;
    if (push) sb_q.push_back(exp);
    @(negedge clk);
    chk("read_valid", 32'(read_valid), 32'(push));
    chk("misalign", 32'(misalign), 32'(exp_mis));
    if (read_valid && sb_q.size() > 0) chk("read_data", read_data, sb_q.pop_front());
    else if (!read_valid) chk("read_data_idle", read_data, 32'h0);
    mem_write = 1'b0;
    mem_read = 1'b0;
  endtask
  task automatic idle();
    step(1'b0, 1'b0, W, W, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask
  task automatic st(input logic [1:0] ss, input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, ss, W, 1'b0, a, d, 1'b0, 32'h0);
  endtask
  task automatic ld(input logic [1:0] ls, input logic u, input logic [31:0] a, input logic [31:0] exp);
    step(1'b0, 1'b1, W, ls, u, a, 32'h0, 1'b1, exp);
  endtask
  task automatic sweep_check();
    for (int k = 1; k <= 64; k++) begin
      if (k == 5) step(1'b0, 1'b1, W, W, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
      else idle();
      chk("busy_sweep", 32'(busy), 32'(k < 64));
      chk("tap_clear", tap_data, 32'h0);
    end
  endtask
  initial begin
    rst = 1'b1;
    n_in = 32'h0;
    exp_mis = 1'b0;
    mem_write = 1'b0;
    mem_read = 1'b0;
    store_size = W;
    load_size = W;
    load_unsigned = 1'b0;
    endereco = 32'h0;
    write_data = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_read_valid", 32'(read_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_tap", tap_data, 32'h0);
    rst = 1'b0;
    sweep_check();
    ld(W, 1'b0, 32'h20, 32'h0);
    st(W, 32'h40, 32'h12345678);
    ld(W, 1'b0, 32'h40, 32'h12345678);
    ld(B, 1'b0, 32'h43, 32'h00000012);
    st(B, 32'h41, 32'h000000AB);
    ld(W, 1'b0, 32'h40, 32'h1234AB78);
    ld(B, 1'b0, 32'h41, 32'hFFFFFFAB);
    ld(B, 1'b1, 32'h41, 32'h000000AB);
    st(H, 32'h46, 32'h00008001);
    ld(H, 1'b0, 32'h46, 32'hFFFF8001);
    ld(H, 1'b1, 32'h46, 32'h00008001);
    ld(W, 1'b0, 32'h44, 32'h80010000);
    step(1'b1, 1'b1, W, W, 1'b0, 32'h40, 32'h0BADF00D, 1'b1, 32'h1234AB78);
    ld(W, 1'b0, 32'h40, 32'h0BADF00D);
    n_in = 32'h000000A5;
    st(B, 32'h00, 32'h00000011);
    ld(W, 1'b0, 32'h00, 32'h00000011);
    ld(W, 1'b0, 32'h00, 32'h000000A5);
    st(W, 32'h28, 32'h0000CAFE);
    chk("tap_lag", tap_data, 32'h0);
    idle();
    chk("tap", tap_data, 32'h0000CAFE);
    ld(W, 1'b0, 32'h100, 32'h0);
    st(W, 32'h140, 32'hDEADBEEF);
    ld(W, 1'b0, 32'h40, 32'h0BADF00D);
    for (int i = 0; i < 4; i++) st(B, 32'h60 + 32'(i), 32'h10 * 32'(i + 1) + 32'(i));
    ld(W, 1'b0, 32'h60, 32'h43322110);
    for (int i = 0; i < 8; i++) st(W, 32'h80 + 32'(4 * i), 32'h9E3779B9 * 32'(i + 1));
    for (int i = 0; i < 8; i++) ld(W, 1'b0, 32'h80 + 32'(4 * i), 32'h9E3779B9 * 32'(i + 1));
`ifdef MEMDADOS_MISALIGN_TRAP_EN
    exp_mis = 1'b1;
    st(W, 32'h51, 32'hFFFFFFFF);
    exp_mis = 1'b0;
    ld(W, 1'b0, 32'h50, 32'h0);
`else
    st(W, 32'h51, 32'hFFFFFFFF);
    ld(W, 1'b0, 32'h50, 32'hFFFFFFFF);
`endif
    rst = 1'b1;
    step(1'b0, 1'b1, W, W, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
    chk("rst_run_busy", 32'(busy), 32'h1);
    chk("rst_run_tap", tap_data, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) idle();
    chk("mid_sweep_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    sweep_check();
    ld(W, 1'b0, 32'h40, 32'h0);
    ld(W, 1'b0, 32'h28, 32'h0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
